// File: rtl/rr_arbiter_16.sv
// Sixteen-requester round-robin arbiter with registered one-hot/binary grant outputs.
// Define ARB_TIMEOUT_EN to force-release any grant held for MAX_HOLD consecutive cycles.
module rr_arbiter_16 #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid,
   output logic        hold_timeout
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]  state;
   logic [3:0]  ptr;
   logic [3:0]  winner;
   logic [3:0]  probe;
   logic        found;
   logic        owner_req;
   logic        force_release;
   logic        release_now;
   logic [3:0]  next_ptr;

   // Search starts at ptr and wraps modulo 16; the first set request wins.
   always_comb begin
      winner = 4'd0;
      probe  = 4'd0;
      found  = 1'b0;
      for (int k = 0; k < 16; k++) begin
         probe = ptr + 4'(k);
         if (!found && req[probe]) begin
            winner = probe;
            found  = 1'b1;
         end
      end
   end

   assign owner_req = req[gnt_idx];
   assign next_ptr  = gnt_idx + 4'd1;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   logic [7:0] hold_cnt;

   // hold_cnt equals the number of cycles the current grant has already been visible.
   assign force_release = (state == GRANT) && owner_req && (hold_cnt == HOLD_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt <= 8'd0;
      end else if (state == IDLE) begin
         hold_cnt <= found ? 8'd1 : 8'd0;
      end else if (!owner_req || force_release) begin
         hold_cnt <= 8'd0;
      end else begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end
`else
   logic unused_max_hold;

   assign unused_max_hold = |32'(MAX_HOLD);
   assign force_release   = 1'b0;
`endif

   assign release_now = (state == GRANT) && (!owner_req || force_release);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= 4'd0;
         gnt          <= 16'd0;
         gnt_idx      <= 4'd0;
         gnt_valid    <= 1'b0;
         hold_timeout <= 1'b0;
      end else begin
         hold_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state     <= GRANT;
                  gnt       <= 16'd1 << winner;
                  gnt_idx   <= winner;
                  gnt_valid <= 1'b1;
               end
            end
            GRANT: begin
               // A release always leaves one dead cycle before the next grant.
               if (release_now) begin
                  state        <= IDLE;
                  ptr          <= next_ptr;
                  gnt          <= 16'd0;
                  gnt_idx      <= 4'd0;
                  gnt_valid    <= 1'b0;
                  hold_timeout <= owner_req && force_release;
               end
            end
            default: begin
               state     <= IDLE;
               gnt       <= 16'd0;
               gnt_idx   <= 4'd0;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench for rr_arbiter_16 (expects MAX_HOLD=8 when ARB_TIMEOUT_EN is defined).
module tb_rr_arbiter_16;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        hold_timeout;

   int tests_run;
   int tests_failed;

   rr_arbiter_16 #(.MAX_HOLD(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .gnt          (gnt),
      .gnt_idx      (gnt_idx),
      .gnt_valid    (gnt_valid),
      .hold_timeout (hold_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] r);
      req = r;
   endtask

   task automatic do_reset();
      req   = 16'h0000;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req   = 16'hFFFF;
      rst_n = 1'b0;
      step();
      step();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid, hold_timeout} !== {16'h0000, 4'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: gnt=%h idx=%0d valid=%b to=%b, expected 0000/0/0/0",
                  gnt, gnt_idx, gnt_valid, hold_timeout);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid} !== {16'h0001, 4'd0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL reset_first_grant: gnt=%h idx=%0d valid=%b, expected 0001/0/1",
                  gnt, gnt_idx, gnt_valid);
      end
      applyStimulus(16'h0000);
      step();
   endtask

   task automatic test_single();
      do_reset();
      applyStimulus(16'h0020);
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++;
         if ({gnt, gnt_idx, gnt_valid} !== {16'h0020, 4'd5, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL single_hold[%0d]: gnt=%h idx=%0d valid=%b, expected 0020/5/1",
                     k, gnt, gnt_idx, gnt_valid);
         end
      end
      applyStimulus(16'h0010);
      step();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid} !== {16'h0000, 4'd0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL single_release: gnt=%h idx=%0d valid=%b, expected 0000/0/0",
                  gnt, gnt_idx, gnt_valid);
      end
      step();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid} !== {16'h0010, 4'd4, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL single_next: gnt=%h idx=%0d valid=%b, expected 0010/4/1",
                  gnt, gnt_idx, gnt_valid);
      end
      applyStimulus(16'h0000);
      step();
   endtask

   task automatic test_round_robin();
      logic [15:0] eg;
      logic [3:0]  ei;
      do_reset();
      applyStimulus(16'hFFFF);
      step();
      for (int i = 0; i <= 16; i++) begin
         ei = 4'(i % 16);
         eg = 16'h0001 << ei;
         for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({gnt, gnt_idx, gnt_valid} !== {eg, ei, 1'b1}) begin
               tests_failed++;
               $display("[TB] FAIL rr_grant[%0d.%0d]: gnt=%h idx=%0d valid=%b, expected %h/%0d/1",
                        i, c, gnt, gnt_idx, gnt_valid, eg, ei);
            end
            if (c == 0) step();
         end
         applyStimulus(16'hFFFF ^ eg);
         step();
         tests_run++;
         if ({gnt, gnt_valid} !== {16'h0000, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL rr_dead[%0d]: gnt=%h valid=%b, expected 0000/0", i, gnt, gnt_valid);
         end
         applyStimulus(16'hFFFF);
         step();
      end
      applyStimulus(16'h0000);
      step();
      step();
   endtask

   task automatic test_wrap();
      do_reset();
      applyStimulus(16'h8000);
      step();
      tests_run++;
      if ({gnt, gnt_idx} !== {16'h8000, 4'd15}) begin
         tests_failed++;
         $display("[TB] FAIL wrap_15: gnt=%h idx=%0d, expected 8000/15", gnt, gnt_idx);
      end
      applyStimulus(16'h0000);
      step();
      applyStimulus(16'h8001);
      step();
      tests_run++;
      if ({gnt, gnt_idx} !== {16'h0001, 4'd0}) begin
         tests_failed++;
         $display("[TB] FAIL wrap_to_0: gnt=%h idx=%0d, expected 0001/0", gnt, gnt_idx);
      end
      applyStimulus(16'h0000);
      step();
      applyStimulus(16'h8001);
      step();
      tests_run++;
      if ({gnt, gnt_idx} !== {16'h8000, 4'd15}) begin
         tests_failed++;
         $display("[TB] FAIL wrap_then_15: gnt=%h idx=%0d, expected 8000/15", gnt, gnt_idx);
      end
      applyStimulus(16'h0000);
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      applyStimulus(16'h0009);
      step();
`ifdef ARB_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         tests_run++;
         if ({gnt, gnt_idx, hold_timeout} !== {16'h0001, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_hold[%0d]: gnt=%h idx=%0d to=%b, expected 0001/0/0",
                     k, gnt, gnt_idx, hold_timeout);
         end
         if (k < 8) step();
      end
      step();
      tests_run++;
      if ({gnt, gnt_valid, hold_timeout} !== {16'h0000, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL timeout_pulse: gnt=%h valid=%b to=%b, expected 0000/0/1",
                  gnt, gnt_valid, hold_timeout);
      end
      step();
      tests_run++;
      if ({gnt, gnt_idx, hold_timeout} !== {16'h0008, 4'd3, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL timeout_next: gnt=%h idx=%0d to=%b, expected 0008/3/0",
                  gnt, gnt_idx, hold_timeout);
      end
`else
      for (int k = 1; k <= 20; k++) begin
         tests_run++;
         if ({gnt, gnt_idx, hold_timeout} !== {16'h0001, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL no_timeout_hold[%0d]: gnt=%h idx=%0d to=%b, expected 0001/0/0",
                     k, gnt, gnt_idx, hold_timeout);
         end
         step();
      end
`endif
      applyStimulus(16'h0000);
      step();
      step();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      applyStimulus(16'h0200);
      step();
      tests_run++;
      if ({gnt, gnt_idx} !== {16'h0200, 4'd9}) begin
         tests_failed++;
         $display("[TB] FAIL mid_setup: gnt=%h idx=%0d, expected 0200/9", gnt, gnt_idx);
      end
      applyStimulus(16'h0300);
      rst_n = 1'b0;
      step();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid} !== {16'h0000, 4'd0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset: gnt=%h idx=%0d valid=%b, expected 0000/0/0",
                  gnt, gnt_idx, gnt_valid);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid} !== {16'h0100, 4'd8, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL mid_regrant: gnt=%h idx=%0d valid=%b, expected 0100/8/1",
                  gnt, gnt_idx, gnt_valid);
      end
      applyStimulus(16'h0000);
      step();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      req          = 16'h0000;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
